// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, write enable, registered read, no reset.
// Latency: write lands at the clock edge; read data is valid the cycle after rd_en.
// Backpressure: none; one access per cycle, read register holds when rd_en is low.
module dmem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Contents survive reset on purpose; only the storage array and read register live here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data bus memory responder: latches a request, waits WAIT_STATES cycles, accesses a 2^ADDR_W RAM.
// Latency: accept at edge T -> ACCESS in cycle T+1+WAIT_STATES, o_Ready pulse in cycle T+2+WAIT_STATES.
// Backpressure: no queuing; requests are ignored while o_Busy, the core waits for o_Ready.
// Optional feature: DMEM_WRITE_PROTECT_EN rejects writes at addresses >= PROTECT_BASE and pulses o_Fault.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                WAIT_STATES  = 1,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hF0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req,
    input  logic [ADDR_W-1:0] i_Addressdata,
    input  logic [DATA_W-1:0] i_Dataout,
    input  logic              i_ReadWrite,
    output logic [DATA_W-1:0] o_Datain,
    output logic              o_Ready,
    output logic              o_Busy,
    output logic              o_Fault
);

    // Counter starts one below the wait count so WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic [DATA_W-1:0] datain_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              ram_re;
    logic              prot_hit;
    logic              read_done;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; bus inputs only matter in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_Req) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and wait countdown; the access uses only these latched copies.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            rw_q     <= RW_READ;
            wait_cnt <= 4'd0;
        end else if (state == IDLE && i_Req) begin
            addr_q   <= i_Addressdata;
            data_q   <= i_Dataout;
            rw_q     <= i_ReadWrite;
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

`ifdef DMEM_WRITE_PROTECT_EN
    assign prot_hit = (rw_q == RW_WRITE) && (addr_q >= PROTECT_BASE);
`else
    assign prot_hit = 1'b0;
    logic unused_protect_base;
    assign unused_protect_base = ^PROTECT_BASE;
`endif

    assign ram_we    = (state == ACCESS) && (rw_q == RW_WRITE) && !prot_hit;
    assign ram_re    = (state == ACCESS) && (rw_q == RW_READ);
    assign read_done = (state == DONE) && (rw_q == RW_READ);

    dmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (i_Clk),
        .wr_en   (ram_we),
        .rd_en   (ram_re),
        .addr    (addr_q),
        .wr_data (data_q),
        .rd_data (ram_rdata)
    );

    // Hold the last read result so o_Datain stays stable until the next read completes.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            datain_q <= '0;
        end else if (read_done) begin
            datain_q <= ram_rdata;
        end
    end

    // Fresh RAM data is visible in the DONE cycle itself, the held copy otherwise.
    assign o_Datain = read_done ? ram_rdata : datain_q;
    assign o_Ready  = (state == DONE);
    assign o_Busy   = (state != IDLE);
    assign o_Fault  = (state == DONE) && prot_hit;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: three responders with WAIT_STATES 1, 0 and 4 on a shared clock/reset.
// Latency: checks ready timing against WAIT_STATES+2 after accept.
// Backpressure: drives one request per instance and waits for o_Ready before the next.
module tb_data_memory_responder;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0][7:0] addr = '0;
    logic [2:0][7:0] wdat = '0;
    logic [2:0]      rwr = '0;
    logic [2:0][7:0] datain;
    logic [2:0]      ready;
    logic [2:0]      busy;
    logic [2:0]      fault;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_responder #(
            .ADDR_W       (8),
            .DATA_W       (8),
            .WAIT_STATES  ((g == 0) ? 1 : ((g == 1) ? 0 : 4)),
            .PROTECT_BASE (8'hF0)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst),
            .i_Req         (req[g]),
            .i_Addressdata (addr[g]),
            .i_Dataout     (wdat[g]),
            .i_ReadWrite   (rwr[g]),
            .o_Datain      (datain[g]),
            .o_Ready       (ready[g]),
            .o_Busy        (busy[g]),
            .o_Fault       (fault[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One access: request for one cycle, then scramble the bus while busy.
    task automatic do_access(input int d, input logic rw, input logic [7:0] a,
                             input logic [7:0] wd, input logic exp_fault, input bit chk,
                             output logic [7:0] rd);
        int lat;
        logic [7:0] exp;
        lat = 0;
        rd  = '0;
        @(negedge clk);
        req[d] = 1'b1; rwr[d] = rw; addr[d] = a; wdat[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0; addr[d] = a + 8'd1; wdat[d] = 8'hFF;
        check("busy_after_accept", 32'(busy[d]), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            if (ready[d]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("ready_latency", 32'(lat), 32'(ws_of(d) + 2));
        if (lat != 0) begin
            check("busy_in_done", 32'(busy[d]), 32'd1);
            check("fault_in_done", 32'(fault[d]), 32'(exp_fault));
            rd = datain[d];
            if (rw == 1'b0 && chk) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty actual=%0h required=expected_entry", datain[d]);
                end else begin
                    exp = sb.pop_front();
                    checks--;
                    check("read_data", 32'(datain[d]), 32'(exp));
                end
            end
            @(negedge clk);
            check("ready_single_pulse", 32'(ready[d]), 32'd0);
            check("busy_after_done", 32'(busy[d]), 32'd0);
        end
    endtask

    // Hold i_Req high for back-to-back reads; expect pulses every WAIT_STATES+3 cycles.
    task automatic cont_test(input int d, input logic [7:0] a, input logic [7:0] exp);
        int ws, n, dbl;
        logic last;
        ws = ws_of(d); n = 0; dbl = 0; last = 1'b0;
        @(negedge clk);
        req[d] = 1'b1; rwr[d] = 1'b0; addr[d] = a;
        @(posedge clk);
        for (int k = 1; k <= 3 * (ws + 3); k++) begin
            @(negedge clk);
            if (ready[d]) begin
                if (last) dbl++;
                n++;
                check("cont_ready_cycle", 32'(k), 32'(n * (ws + 3) - 1));
                check("cont_datain", 32'(datain[d]), 32'(exp));
                if (n == 3) req[d] = 1'b0;
            end
            last = ready[d];
        end
        check("cont_pulse_count", 32'(n), 32'd3);
        check("cont_double_pulse", 32'(dbl), 32'd0);
        @(negedge clk);
        check("cont_idle_after", 32'(busy[d]), 32'd0);
    endtask

    typedef struct {
        int         d;
        logic       rw;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] rd;
        logic [7:0] prior;
        int         nrdy;

        tbl[0]  = '{0, 1'b1, 8'h12, 8'hA5, 8'h00};
        tbl[1]  = '{0, 1'b0, 8'h12, 8'h00, 8'hA5};
        tbl[2]  = '{0, 1'b1, 8'h06, 8'h11, 8'h00};
        tbl[3]  = '{0, 1'b1, 8'h05, 8'h3C, 8'h00};
        tbl[4]  = '{0, 1'b0, 8'h06, 8'h00, 8'h11};
        tbl[5]  = '{0, 1'b0, 8'h05, 8'h00, 8'h3C};
        tbl[6]  = '{1, 1'b1, 8'h40, 8'h5A, 8'h00};
        tbl[7]  = '{1, 1'b0, 8'h40, 8'h00, 8'h5A};
        tbl[8]  = '{1, 1'b1, 8'h00, 8'h01, 8'h00};
        tbl[9]  = '{1, 1'b0, 8'h00, 8'h00, 8'h01};
        tbl[10] = '{2, 1'b1, 8'h20, 8'hAB, 8'h00};
        tbl[11] = '{2, 1'b0, 8'h20, 8'h00, 8'hAB};

        // Reset values
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(ready[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_fault", 32'(fault[d]), 32'd0);
            check("rst_datain", 32'(datain[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy[0]), 32'd0);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rw == 1'b0) sb.push_back(tbl[i].exp);
            do_access(tbl[i].d, tbl[i].rw, tbl[i].a, tbl[i].wd, 1'b0, 1'b1, rd);
        end

        // Held read data persists across a following write
        do_access(0, 1'b1, 8'h30, 8'h42, 1'b0, 1'b1, rd);
        check("datain_held_after_write", 32'(datain[0]), 32'h3C);

        // Continuous request, WAIT_STATES 1 and 0
        cont_test(0, 8'h12, 8'hA5);
        cont_test(1, 8'h40, 8'h5A);

        // Reset during WAIT on the WAIT_STATES=4 instance
        @(negedge clk);
        req[2] = 1'b1; rwr[2] = 1'b1; addr[2] = 8'h20; wdat[2] = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy[2]), 32'd0);
        check("midrst_ready", 32'(ready[2]), 32'd0);
        check("midrst_fault", 32'(fault[2]), 32'd0);
        check("midrst_datain", 32'(datain[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nrdy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready[2]) nrdy++;
        end
        check("midrst_no_ready", 32'(nrdy), 32'd0);
        sb.push_back(8'hAB);
        do_access(2, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, rd);

        // Protected region behaviour
`ifdef DMEM_WRITE_PROTECT_EN
        do_access(0, 1'b0, 8'hF3, 8'h00, 1'b0, 1'b0, prior);
        do_access(0, 1'b1, 8'hF3, 8'h99, 1'b1, 1'b1, rd);
        sb.push_back(prior);
        do_access(0, 1'b0, 8'hF3, 8'h00, 1'b0, 1'b1, rd);
        do_access(0, 1'b1, 8'hEF, 8'h5E, 1'b0, 1'b1, rd);
        sb.push_back(8'h5E);
        do_access(0, 1'b0, 8'hEF, 8'h00, 1'b0, 1'b1, rd);
`else
        prior = 8'h99;
        do_access(0, 1'b1, 8'hF3, prior, 1'b0, 1'b1, rd);
        sb.push_back(prior);
        do_access(0, 1'b0, 8'hF3, 8'h00, 1'b0, 1'b1, rd);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
